// File: rtl/qpsk_hard_rx_pkg.sv
// qpsk_pkg: shared QPSK receiver constants, FSM states and bit/symbol mapping helpers.
package qpsk_pkg;
   localparam int BI      = 12;
   localparam int NUM_SYM = 320000;
   // Bit value that the transmitter sends as -A; the other value goes out as +A.
   localparam logic NEG_BIT = 1'b1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   function automatic logic decide(logic neg);
      return neg ? NEG_BIT : ~NEG_BIT;
   endfunction
   function automatic logic [1:0] popcount2(logic [1:0] v);
      return {1'b0, v[1]} + {1'b0, v[0]};
   endfunction
endpackage

// File: rtl/qpsk_hard_rx_if.sv
// qpsk_hard_rx_if: control, reference, sample and result signals of the hard-decision receiver.
interface qpsk_hard_rx_if #(
   parameter int BI    = 12,
   parameter int SYM_W = 19,
   parameter int ERR_W = 20
);
   logic                    start;
   logic                    tx_valid;
   logic [1:0]              tx_bits;
   logic                    rx_valid;
   logic signed [BI-1:0]    y_real;
   logic signed [BI-1:0]    y_imag;
   logic                    hard_valid;
   logic [1:0]              hard_bits;
   logic [SYM_W-1:0]        sym_count;
   logic [ERR_W-1:0]        bit_errors;
   logic                    busy;
   logic                    done;
   logic                    overflow;
   logic                    underflow;
   modport master (
      output start, tx_valid, tx_bits, rx_valid, y_real, y_imag,
      input  hard_valid, hard_bits, sym_count, bit_errors, busy, done, overflow, underflow
   );
   modport slave (
      input  start, tx_valid, tx_bits, rx_valid, y_real, y_imag,
      output hard_valid, hard_bits, sym_count, bit_errors, busy, done, overflow, underflow
   );
endinterface

// File: rtl/qpsk_hard_rx_ref_fifo.sv
// ref_fifo: 2-bit synchronous FIFO holding transmitted reference bits; a push on a full FIFO
// is accepted only when a pop frees a slot on the same edge.
module ref_fifo #(
   parameter int DEPTH = 16
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       flush,
   input  logic       push,
   input  logic       pop,
   input  logic [1:0] din,
   output logic [1:0] dout,
   output logic       full,
   output logic       empty
);
   localparam int AW = $clog2(DEPTH);
   logic [1:0]  mem [DEPTH];
   logic [AW:0] wp, rp;
   logic        wr, rd;
   assign empty = wp == rp;
   assign full  = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
   assign rd    = pop && !empty;
   assign wr    = push && (!full || rd);
   assign dout  = mem[rp[AW-1:0]];
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wp <= '0;
         rp <= '0;
      end else if (flush) begin
         wp <= '0;
         rp <= '0;
      end else begin
         wp <= wr ? wp + 1'b1 : wp;
         rp <= rd ? rp + 1'b1 : rp;
      end
   always_ff @(posedge clk)
      if (wr && !flush) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/qpsk_hard_rx.sv
// qpsk_hard_rx: hard-decision QPSK receiver; compares decisions with buffered reference bits
// and accumulates symbol and bit-error counts for one BER run.
module qpsk_hard_rx #(
   parameter int BI         = qpsk_pkg::BI,
   parameter int NUM_SYM    = qpsk_pkg::NUM_SYM,
   parameter int FIFO_DEPTH = 16,
   parameter int SYM_W      = 19,
   parameter int ERR_W      = 20
)(
   input logic           clk,
   input logic           reset,
   qpsk_hard_rx_if.slave bus
);
   import qpsk_pkg::*;
   state_t               state_q, state_d;
   logic signed [BI-1:0] yr, yi;
   logic [1:0]           dec, ref_bits, errs, hard_bits_q;
   logic                 run, push, rx, pop, empty, full, last;
   logic                 hard_valid_q, overflow_q, underflow_q;
   logic [SYM_W-1:0]     sym_q;
   logic [ERR_W-1:0]     err_q;
   logic [ERR_W:0]       err_sum;
   assign yr      = bus.y_real;
   assign yi      = bus.y_imag;
   assign dec     = {decide(yr < 0), decide(yi < 0)};
   // A start cycle ignores data inputs; the run begins on the following cycle.
   assign run     = state_q == RUN && !bus.start;
   assign push    = run && bus.tx_valid;
   assign rx      = run && bus.rx_valid;
   assign pop     = rx && !empty;
   assign errs    = popcount2(ref_bits ^ dec);
   assign err_sum = {1'b0, err_q} + (ERR_W+1)'(errs);
   assign last    = sym_q == SYM_W'(NUM_SYM - 1);
   ref_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (bus.start),
      .push  (push),
      .pop   (pop),
      .din   (bus.tx_bits),
      .dout  (ref_bits),
      .full  (full),
      .empty (empty)
   );
   always_comb begin
      state_d = state_q;
      if (bus.start) state_d = RUN;
      else if (run && pop && last) state_d = DONE;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) state_q <= IDLE;
      else state_q <= state_d;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         hard_valid_q <= 1'b0;
         hard_bits_q  <= 2'b00;
         sym_q        <= '0;
         err_q        <= '0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else if (bus.start) begin
         hard_valid_q <= 1'b0;
         sym_q        <= '0;
         err_q        <= '0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         hard_valid_q <= rx;
         hard_bits_q  <= rx ? dec : hard_bits_q;
         sym_q        <= pop ? sym_q + 1'b1 : sym_q;
         err_q        <= !pop ? err_q : err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
         overflow_q   <= overflow_q | (push & full & !pop);
         underflow_q  <= underflow_q | (rx & empty);
      end
   assign bus.hard_valid = hard_valid_q;
   assign bus.hard_bits  = hard_bits_q;
   assign bus.sym_count  = sym_q;
   assign bus.bit_errors = err_q;
   assign bus.busy       = state_q == RUN;
   assign bus.done       = state_q == DONE;
   assign bus.overflow   = overflow_q;
   assign bus.underflow  = underflow_q;
endmodule

// File: tb/tb_qpsk_hard_rx.sv
// tb_qpsk_hard_rx: table vectors, directed corner sequences and random traffic against a queue-based model.
module tb_qpsk_hard_rx;
   localparam int NS      = 1000;
   localparam int ERR_MAX = (1 << 20) - 1;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   qpsk_hard_rx_if #(.BI(12), .SYM_W(19), .ERR_W(20)) bus_a ();
   qpsk_hard_rx_if #(.BI(12), .SYM_W(19), .ERR_W(20)) bus_b ();
   qpsk_hard_rx #(.BI(12), .NUM_SYM(NS), .FIFO_DEPTH(16), .SYM_W(19), .ERR_W(20))
      dut_a (.clk(clk), .reset(reset), .bus(bus_a));
   qpsk_hard_rx #(.BI(12), .NUM_SYM(8), .FIFO_DEPTH(16), .SYM_W(19), .ERR_W(20))
      dut_b (.clk(clk), .reset(reset), .bus(bus_b));
   assign bus_b.start    = bus_a.start;
   assign bus_b.tx_valid = bus_a.tx_valid;
   assign bus_b.tx_bits  = bus_a.tx_bits;
   assign bus_b.rx_valid = bus_a.rx_valid;
   assign bus_b.y_real   = bus_a.y_real;
   assign bus_b.y_imag   = bus_a.y_imag;

   int passed = 0, total = 0;
   logic [1:0] q[$];
   bit m_run, m_done, m_hv, m_ovf, m_udf;
   logic [1:0] m_hb;
   int m_sym, m_err;

   typedef struct {
      bit txv; logic [1:0] txb; bit rxv; int yr; int yi;
      logic [1:0] hb; int err; int sym;
   } vec_t;
   vec_t tv[6];

   task automatic chk(string n, longint act, longint exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", n, act, exp);
   endtask

   function automatic int amp(logic b);
      return b ? -1024 : 1024;
   endfunction

   task automatic model_reset();
      q.delete();
      m_run = 0; m_done = 0; m_hv = 0; m_ovf = 0; m_udf = 0;
      m_hb = 2'b00; m_sym = 0; m_err = 0;
   endtask

   // Receiver behaviour per clock: decide by sign, compare with the oldest reference, count.
   task automatic model_step(bit st, bit txv, logic [1:0] txb, bit rxv, int yr, int yi);
      logic [1:0] dec, r;
      m_hv = 0;
      if (st) begin
         q.delete();
         m_sym = 0; m_err = 0; m_ovf = 0; m_udf = 0; m_run = 1; m_done = 0;
      end else if (m_run) begin
         if (rxv) begin
            dec = {yr < 0, yi < 0};
            m_hv = 1;
            m_hb = dec;
            if (q.size() == 0) m_udf = 1;
            else begin
               r = q.pop_front();
               m_err = m_err + $countones(r ^ dec);
               if (m_err > ERR_MAX) m_err = ERR_MAX;
               m_sym++;
               if (m_sym == NS) begin
                  m_run = 0;
                  m_done = 1;
               end
            end
         end
         if (txv) begin
            if (q.size() < 16) q.push_back(txb);
            else m_ovf = 1;
         end
      end
   endtask

   task automatic cmp_all(string t);
      chk({t, ".hard_valid"}, bus_a.hard_valid, m_hv);
      chk({t, ".hard_bits"}, bus_a.hard_bits, m_hb);
      chk({t, ".sym_count"}, bus_a.sym_count, m_sym);
      chk({t, ".bit_errors"}, bus_a.bit_errors, m_err);
      chk({t, ".busy"}, bus_a.busy, m_run);
      chk({t, ".done"}, bus_a.done, m_done);
      chk({t, ".overflow"}, bus_a.overflow, m_ovf);
      chk({t, ".underflow"}, bus_a.underflow, m_udf);
   endtask

   task automatic cycle(string t, bit st, bit txv, logic [1:0] txb, bit rxv, int yr, int yi);
      bus_a.start = st; bus_a.tx_valid = txv; bus_a.tx_bits = txb;
      bus_a.rx_valid = rxv; bus_a.y_real = 12'(yr); bus_a.y_imag = 12'(yi);
      model_step(st, txv, txb, rxv, yr, yi);
      @(posedge clk);
      #1;
      cmp_all(t);
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1:0] v[24];
      bus_a.start = 0; bus_a.tx_valid = 0; bus_a.tx_bits = 0;
      bus_a.rx_valid = 0; bus_a.y_real = 0; bus_a.y_imag = 0;
      model_reset();
      #12;
      cmp_all("reset");
      @(negedge clk) reset = 0;

      // Basic decisions and error counting from a fixed table.
      tv[0] = '{1, 2'b00, 0, 0,    0,    2'b00, 0, 0};
      tv[1] = '{0, 2'b00, 1, 300,  5,    2'b00, 0, 1};
      tv[2] = '{1, 2'b10, 0, 0,    0,    2'b00, 0, 1};
      tv[3] = '{0, 2'b00, 1, 300,  0,    2'b00, 1, 2};
      tv[4] = '{1, 2'b01, 0, 0,    0,    2'b00, 1, 2};
      tv[5] = '{0, 2'b00, 1, -1,   2047, 2'b10, 3, 3};
      cycle("start1", 1, 0, 0, 0, 0, 0);
      foreach (tv[i]) begin
         cycle("tbl", 0, tv[i].txv, tv[i].txb, tv[i].rxv, tv[i].yr, tv[i].yi);
         chk($sformatf("tbl%0d.hard_bits", i), bus_a.hard_bits, tv[i].hb);
         chk($sformatf("tbl%0d.bit_errors", i), bus_a.bit_errors, tv[i].err);
         chk($sformatf("tbl%0d.sym_count", i), bus_a.sym_count, tv[i].sym);
      end

      // Latency-4 noiseless stream.
      cycle("start3", 1, 0, 0, 0, 0, 0);
      foreach (v[i]) v[i] = 2'($urandom_range(3));
      for (int i = 0; i < 24; i++)
         cycle("stream", 0, i < 20, v[i < 20 ? i : 0], i >= 4,
               amp(v[i >= 4 ? i - 4 : 0][1]), amp(v[i >= 4 ? i - 4 : 0][0]));
      chk("stream.sym_count", bus_a.sym_count, 20);
      chk("stream.bit_errors", bus_a.bit_errors, 0);
      chk("stream.overflow", bus_a.overflow, 0);
      chk("stream.underflow", bus_a.underflow, 0);

      // Overflow: 17 pushes keep exactly 16 entries.
      cycle("start4", 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 17; i++) cycle("ovf_push", 0, 1, v[i], 0, 0, 0);
      chk("ovf.overflow", bus_a.overflow, 1);
      for (int i = 0; i < 16; i++) cycle("ovf_drain", 0, 0, 0, 1, amp(v[i][1]), amp(v[i][0]));
      chk("ovf.sym16", bus_a.sym_count, 16);
      chk("ovf.no_underflow", bus_a.underflow, 0);
      cycle("ovf_extra", 0, 0, 0, 1, 100, 100);
      chk("ovf.extra_underflow", bus_a.underflow, 1);
      // Underflow right after restart, with a same-cycle push that must be kept.
      cycle("start4b", 1, 0, 0, 0, 0, 0);
      cycle("udf", 0, 1, 2'b11, 1, 7, -7);
      chk("udf.underflow", bus_a.underflow, 1);
      chk("udf.hard_valid", bus_a.hard_valid, 1);
      chk("udf.sym_count", bus_a.sym_count, 0);
      cycle("udf_pop", 0, 0, 0, 1, -5, -5);
      chk("udf.stored_push", bus_a.sym_count, 1);

      // Completion on the 8-symbol instance.
      cycle("start5", 1, 0, 0, 0, 0, 0);
      cycle("done_pre", 0, 1, v[0], 0, 0, 0);
      for (int k = 1; k <= 8; k++) begin
         cycle("done_run", 0, 1, v[k], 1, amp(v[k-1][1]), amp(v[k-1][0]));
         chk($sformatf("b.sym%0d", k), bus_b.sym_count, k);
         chk($sformatf("b.busy%0d", k), bus_b.busy, k < 8);
         chk($sformatf("b.done%0d", k), bus_b.done, k == 8);
      end
      cycle("done_post", 0, 0, 0, 1, amp(v[8][1]), amp(v[8][0]));
      chk("b.sym_after_done", bus_b.sym_count, 8);
      chk("b.hv_after_done", bus_b.hard_valid, 0);
      chk("b.errors", bus_b.bit_errors, 0);

      // Asynchronous reset in mid-run.
      cycle("start6", 1, 0, 0, 0, 0, 0);
      cycle("mid_pre", 0, 1, v[0], 0, 0, 0);
      for (int k = 1; k <= 5; k++) cycle("mid", 0, 1, v[k], 1, amp(v[k-1][1]), amp(v[k-1][0]));
      chk("mid.sym5", bus_a.sym_count, 5);
      #3 reset = 1;
      #1;
      model_reset();
      cmp_all("async_reset");
      bus_a.tx_valid = 0; bus_a.rx_valid = 0;
      @(negedge clk) reset = 0;
      cycle("start6b", 1, 0, 0, 0, 0, 0);
      cycle("fresh_push", 0, 1, 2'b01, 0, 0, 0);
      cycle("fresh_rx", 0, 0, 0, 1, 1024, -1024);
      chk("fresh.sym", bus_a.sym_count, 1);

      // Random traffic with noisy samples and occasional restarts.
      for (int i = 0; i < 400; i++) begin
         int yr, yi;
         yr = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(4095)) - 2048;
         yi = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(4095)) - 2048;
         cycle("rand", $urandom_range(59) == 0, $urandom_range(99) < 55, 2'($urandom_range(3)),
               $urandom_range(99) < 55, yr, yi);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
